// File: rtl/cordic_pkg.sv
// Shared types and constants for the vectoring CORDIC custom instruction.
// Fixed-point formats: x/y are Q2.30, z and the angle result are Q3.29.
package cordic_pkg;

   localparam int DATA_W     = 32;
   localparam int XY_FRAC    = 30;
   localparam int Z_FRAC     = 29;
   localparam int MAX_ITER   = 24;
   localparam int ITER_CNT_W = 5;

   // Inverse CORDIC gain in Q2.30, and the pre-rotation angles in Q3.29.
   localparam logic signed [DATA_W-1:0] K_GAIN  = 32'sh26DD3B6A;
   localparam logic signed [DATA_W-1:0] HALF_PI = 32'sh3243F6A9;
   localparam logic signed [DATA_W-1:0] PI      = 32'sh6487ED51;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ITER,
      ST_SCALE,
      ST_DONE
   } state_e;

   // NOTE: this table is a constant ROM; it is never written, so it has no reset.
   localparam logic [DATA_W-1:0] ATAN_TABLE [MAX_ITER] = '{
      32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
      32'h01FF55BB, 32'h00FFEAAB, 32'h007FFD55, 32'h003FFFAB,
      32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
      32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000,
      32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
      32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040
   };

endpackage

// File: rtl/cordic_vec_step.sv
// One combinational vectoring micro-rotation: drives y toward zero and
// accumulates the rotated angle in z. Both updates use the incoming x and y.
module cordic_vec_step
   import cordic_pkg::*;
#(
   parameter int W       = 36,
   parameter int SHIFT_W = ITER_CNT_W
) (
   input  logic signed [W-1:0]       x_i,
   input  logic signed [W-1:0]       y_i,
   input  logic signed [W-1:0]       z_i,
   input  logic signed [W-1:0]       angle_i,
   input  logic        [SHIFT_W-1:0] shift_i,
   output logic signed [W-1:0]       x_o,
   output logic signed [W-1:0]       y_o,
   output logic signed [W-1:0]       z_o
);

   logic signed [W-1:0] x_sh;
   logic signed [W-1:0] y_sh;

   assign x_sh = x_i >>> shift_i;
   assign y_sh = y_i >>> shift_i;

   // NOTE: defaults first so every path assigns every output and no latch is inferred.
   always_comb begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + angle_i;
      if (y_i[W-1]) begin
         x_o = x_i - y_sh;
         y_o = y_i + x_sh;
         z_o = z_i - angle_i;
      end
   end

endmodule

// File: rtl/cordic_vec.sv
// Iterative vectoring-mode CORDIC custom instruction: returns atan2(y, x)
// (n=0) or sqrt(x^2+y^2) (n=1) using a single shared micro-rotation stage.
module cordic_vec
   import cordic_pkg::*;
#(
   parameter int ITERATIONS = 16,
   parameter int GUARD      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              start,
   input  logic              n,
   input  logic [DATA_W-1:0] dataa,
   input  logic [DATA_W-1:0] datab,
   output logic [DATA_W-1:0] result,
   output logic              done
);

   localparam int W         = DATA_W + GUARD;
   localparam int PROD_W    = W + DATA_W;
   localparam int MAG_SHIFT = 2 * XY_FRAC - Z_FRAC;

   localparam logic [ITER_CNT_W-1:0] LAST_ITER   = ITER_CNT_W'(ITERATIONS - 1);
   localparam logic signed [W-1:0]   HALF_PI_EXT = W'(HALF_PI);

   state_e                  state_q;
   logic [DATA_W-1:0]       opa_q;
   logic [DATA_W-1:0]       opb_q;
   logic                    mag_q;
   logic                    zero_q;
   logic [ITER_CNT_W-1:0]   iter_q;
   logic signed [W-1:0]     x_q;
   logic signed [W-1:0]     y_q;
   logic signed [W-1:0]     z_q;
   logic [DATA_W-1:0]       scaled_q;
   logic [DATA_W-1:0]       result_q;
   logic                    done_q;

   logic signed [W-1:0]     x_d;
   logic signed [W-1:0]     y_d;
   logic signed [W-1:0]     z_d;

   logic signed [W-1:0]     opa_ext;
   logic signed [W-1:0]     opb_ext;
   logic signed [W-1:0]     atan_ext;
   logic signed [PROD_W-1:0] x_wide;
   logic signed [PROD_W-1:0] k_wide;
   logic signed [PROD_W-1:0] mag_prod;
   logic [DATA_W-1:0]       mag_val;
   logic                    unused_prod;

   assign opa_ext  = {{GUARD{opa_q[DATA_W-1]}}, opa_q};
   assign opb_ext  = {{GUARD{opb_q[DATA_W-1]}}, opb_q};
   assign atan_ext = W'(ATAN_TABLE[iter_q]);

   // x is never negative after pre-rotation; (x*K)>>>30 then drops one more
   // fraction bit to move from Q2.30 to Q3.29.
   assign x_wide      = PROD_W'(x_q);
   assign k_wide      = PROD_W'(K_GAIN);
   assign mag_prod    = x_wide * k_wide;
   assign mag_val     = mag_prod[MAG_SHIFT +: DATA_W];
   assign unused_prod = ^{mag_prod[PROD_W-1:MAG_SHIFT+DATA_W], mag_prod[MAG_SHIFT-1:0]};

   cordic_vec_step #(
      .W       (W),
      .SHIFT_W (ITER_CNT_W)
   ) u_step (
      .x_i     (x_q),
      .y_i     (y_q),
      .z_i     (z_q),
      .angle_i (atan_ext),
      .shift_i (iter_q),
      .x_o     (x_d),
      .y_o     (y_d),
      .z_o     (z_d)
   );

   // NOTE: sequential state is written with non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         mag_q    <= 1'b0;
         zero_q   <= 1'b0;
         iter_q   <= '0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         scaled_q <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else if (clk_en) begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  opa_q   <= dataa;
                  opb_q   <= datab;
                  mag_q   <= n;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               zero_q <= (opa_q == '0) && (opb_q == '0);
               iter_q <= '0;
               // Quarter-turn pre-rotation keeps x non-negative for the loop.
               if (!opa_q[DATA_W-1]) begin
                  x_q <= opa_ext;
                  y_q <= opb_ext;
                  z_q <= '0;
               end else if (!opb_q[DATA_W-1]) begin
                  x_q <= opb_ext;
                  y_q <= -opa_ext;
                  z_q <= HALF_PI_EXT;
               end else begin
                  x_q <= -opb_ext;
                  y_q <= opa_ext;
                  z_q <= -HALF_PI_EXT;
               end
               state_q <= ST_ITER;
            end
            ST_ITER: begin
               x_q    <= x_d;
               y_q    <= y_d;
               z_q    <= z_d;
               iter_q <= iter_q + ITER_CNT_W'(1);
               if (iter_q == LAST_ITER) begin
                  state_q <= ST_SCALE;
               end
            end
            ST_SCALE: begin
               if (zero_q) begin
                  scaled_q <= '0;
               end else if (mag_q) begin
                  scaled_q <= mag_val;
               end else begin
                  scaled_q <= z_q[DATA_W-1:0];
               end
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               result_q <= scaled_q;
               done_q   <= 1'b1;
               state_q  <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign result = result_q;
   assign done   = done_q;

endmodule

// File: tb/tb_cordic_vec.sv
// Self-checking bench for cordic_vec: directed and random operands against a
// real-arithmetic atan2/hypot model, plus latency, abort and clock-enable checks.
module tb_cordic_vec;

   localparam int     ITERATIONS = 16;
   localparam int     LATENCY    = ITERATIONS + 3;
   localparam int     TIMEOUT    = 200;
   localparam longint TOL        = 64'h10000;
   localparam longint TWO_PI_Q29 = 64'd3373259426;
   localparam real    Q30        = 1073741824.0;
   localparam real    Q29        = 536870912.0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        nn;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        start;
   logic        n;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic [31:0] result;
   logic        done;

   int checks   = 0;
   int failures = 0;
   bit stall_at [256];

   cordic_vec #(
      .ITERATIONS (ITERATIONS),
      .GUARD      (4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .start  (start),
      .n      (n),
      .dataa  (dataa),
      .datab  (datab),
      .result (result),
      .done   (done)
   );

   always #5 clk = ~clk;

   // Ideal answer in Q3.29, rounded to nearest.
   function automatic longint ref_model(input logic [31:0] a, input logic [31:0] b,
                                        input logic nn);
      real xr;
      real yr;
      real r;
      if (a == 32'h0 && b == 32'h0) return 0;
      xr = $itor($signed(a)) / Q30;
      yr = $itor($signed(b)) / Q30;
      r  = nn ? $sqrt(xr * xr + yr * yr) : $atan2(yr, xr);
      return longint'($rtoi(r * Q29 + ((r >= 0.0) ? 0.5 : -0.5)));
   endfunction

   // Absolute distance; angles are compared around the circle.
   function automatic longint err_dist(input logic [31:0] got, input longint exp,
                                       input logic angle);
      longint d;
      d = longint'($signed(got)) - exp;
      if (angle) begin
         if (d > TWO_PI_Q29 / 2) d = d - TWO_PI_Q29;
         else if (d < -(TWO_PI_Q29 / 2)) d = d + TWO_PI_Q29;
      end
      return (d < 0) ? -d : d;
   endfunction

   function automatic real mag2(input logic [31:0] a, input logic [31:0] b);
      real xr;
      real yr;
      xr = $itor($signed(a)) / Q30;
      yr = $itor($signed(b)) / Q30;
      return xr * xr + yr * yr;
   endfunction

   // Issues one operation; lat counts enabled+disabled cycles from the start edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic nn,
                         input int restart_at, input bit stalled,
                         output int lat, output logic [31:0] res);
      @(negedge clk);
      dataa  = a;
      datab  = b;
      n      = nn;
      clk_en = 1'b1;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      while (done !== 1'b1 && lat < TIMEOUT) begin
         clk_en = !(stalled && stall_at[lat]);
         start  = (lat == restart_at);
         dataa  = (lat == restart_at) ? 32'h12345678 : a;
         @(negedge clk);
         lat++;
      end
      clk_en = 1'b1;
      start  = 1'b0;
      dataa  = a;
      res    = result;
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL timeout: no done after %0d cycles, required within %0d", lat, TIMEOUT);
      end else begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_width: done=%b one cycle after pulse, required 0", done);
         end
      end
   endtask

   task automatic test_reset();
      int pulses;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL reset_done: got %b required 0", done);
      end
      checks++;
      if (result !== 32'h0) begin
         failures++;
         $display("FAIL reset_result: got %h required 00000000", result);
      end
      reset  = 1'b0;
      pulses = 0;
      repeat (LATENCY + 5) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL idle_quiet: got %0d done pulses required 0", pulses);
      end
   endtask

   task automatic test_directed();
      vec_t        v [5];
      int          lat;
      logic [31:0] res;
      v[0] = '{32'h40000000, 32'h40000000, 1'b0, 32'h1921FB54};
      v[1] = '{32'hC0000000, 32'h00000000, 1'b0, 32'h6487ED51};
      v[2] = '{32'hC0000000, 32'hFFFFFFFF, 1'b0, 32'h9B7812AF};
      v[3] = '{32'h26666666, 32'h33333333, 1'b1, 32'h20000000};
      v[4] = '{32'h26666666, 32'h33333333, 1'b0, 32'h1DAC6705};
      foreach (v[i]) begin
         run_op(v[i].a, v[i].b, v[i].nn, -1, 1'b0, lat, res);
         checks++;
         if (lat != LATENCY) begin
            failures++;
            $display("FAIL directed%0d_latency: got %0d required %0d", i, lat, LATENCY);
         end
         checks++;
         if (err_dist(res, longint'($signed(v[i].exp)), !v[i].nn) > TOL) begin
            failures++;
            $display("FAIL directed%0d_value: got %h required %h +/- %h", i, res, v[i].exp, TOL);
         end
      end
   endtask

   task automatic test_zero();
      int          lat;
      int          pulses;
      logic [31:0] res;
      for (int k = 0; k < 2; k++) begin
         run_op(32'h0, 32'h0, k[0], 6, 1'b0, lat, res);
         checks++;
         if (lat != LATENCY) begin
            failures++;
            $display("FAIL zero_n%0d_latency: got %0d required %0d", k, lat, LATENCY);
         end
         checks++;
         if (res !== 32'h0) begin
            failures++;
            $display("FAIL zero_n%0d_value: got %h required 00000000", k, res);
         end
         pulses = 0;
         repeat (LATENCY + 5) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
         end
         checks++;
         if (pulses != 0) begin
            failures++;
            $display("FAIL zero_n%0d_restart_ignored: got %0d extra done pulses required 0", k, pulses);
         end
      end
   endtask

   task automatic test_random(input int count);
      logic [31:0] a;
      logic [31:0] b;
      logic        nn;
      int          lat;
      logic [31:0] res;
      longint      exp;
      for (int k = 0; k < count; k++) begin
         do begin
            a = $urandom;
            b = $urandom;
         end while (mag2(a, b) < 0.0625);
         nn  = 1'($urandom_range(0, 1));
         exp = ref_model(a, b, nn);
         run_op(a, b, nn, -1, 1'b0, lat, res);
         checks++;
         if (lat != LATENCY) begin
            failures++;
            $display("FAIL random%0d_latency: got %0d required %0d", k, lat, LATENCY);
         end
         checks++;
         if (err_dist(res, exp, !nn) > TOL) begin
            failures++;
            $display("FAIL random%0d_value: a=%h b=%h n=%b got %h required %h +/- %h",
                     k, a, b, nn, res, 32'(exp), TOL);
         end
      end
   endtask

   task automatic test_reset_mid();
      int          lat;
      int          pulses;
      logic [31:0] res;
      run_op(32'h40000000, 32'h40000000, 1'b0, -1, 1'b0, lat, res);
      checks++;
      if (err_dist(res, 64'sd421657428, 1'b1) > TOL) begin
         failures++;
         $display("FAIL abort_setup_value: got %h required 1921fb54 +/- %h", res, TOL);
      end
      @(negedge clk);
      dataa = 32'h26666666;
      datab = 32'h33333333;
      n     = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL abort_done: got %b required 0", done);
      end
      checks++;
      if (result !== 32'h0) begin
         failures++;
         $display("FAIL abort_result: got %h required 00000000", result);
      end
      pulses = 0;
      repeat (LATENCY + 5) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL abort_quiet: got %0d done pulses required 0", pulses);
      end
      run_op(32'h26666666, 32'h33333333, 1'b1, -1, 1'b0, lat, res);
      checks++;
      if (lat != LATENCY) begin
         failures++;
         $display("FAIL abort_restart_latency: got %0d required %0d", lat, LATENCY);
      end
      checks++;
      if (err_dist(res, 64'sd536870912, 1'b0) > TOL) begin
         failures++;
         $display("FAIL abort_restart_value: got %h required 20000000 +/- %h", res, TOL);
      end
   endtask

   task automatic test_clk_en();
      logic [31:0] a;
      logic [31:0] b;
      int          lat_ref;
      int          lat_stall;
      int          picked;
      int          slot;
      logic [31:0] res_ref;
      logic [31:0] res_stall;
      for (int k = 0; k < 2; k++) begin
         do begin
            a = $urandom;
            b = $urandom;
         end while (mag2(a, b) < 0.0625);
         run_op(a, b, k[0], -1, 1'b0, lat_ref, res_ref);
         checks++;
         if (err_dist(res_ref, ref_model(a, b, k[0]), !k[0]) > TOL) begin
            failures++;
            $display("FAIL clk_en%0d_ref_value: got %h required %h +/- %h",
                     k, res_ref, 32'(ref_model(a, b, k[0])), TOL);
         end
         foreach (stall_at[i]) stall_at[i] = 1'b0;
         picked = 0;
         while (picked < 5) begin
            slot = $urandom_range(3, 14);
            if (!stall_at[slot]) begin
               stall_at[slot] = 1'b1;
               picked++;
            end
         end
         run_op(a, b, k[0], -1, 1'b1, lat_stall, res_stall);
         checks++;
         if (lat_stall != LATENCY + 5) begin
            failures++;
            $display("FAIL clk_en%0d_latency: got %0d required %0d", k, lat_stall, LATENCY + 5);
         end
         checks++;
         if (res_stall !== res_ref) begin
            failures++;
            $display("FAIL clk_en%0d_result: got %h required %h", k, res_stall, res_ref);
         end
      end
   endtask

   initial begin
      reset  = 1'b1;
      clk_en = 1'b1;
      start  = 1'b0;
      n      = 1'b0;
      dataa  = 32'h0;
      datab  = 32'h0;
      test_reset();
      test_directed();
      test_zero();
      test_random(24);
      test_reset_mid();
      test_clk_en();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule
